arbiter_for_out_rep: RTL and testbench
======================================

# arbiter_for_OUT_rep

Packet-atomic arbiter for the outgoing reply port (OUT_rep) of the communication assist. It shares one network-facing reply register between three reply sources: instruction cache, data cache and memory. Once a source wins, it holds the port until its tail flit has been transferred. A flit-count watchdog recovers the port if a tail flit never arrives.

## Interface
Parameters:
- MAX_FLITS, default 11: maximum flits per packet, head and tail included; range 2..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- OUT_rep_rdy  in  1  OUT_rep can accept one flit this cycle
- v_ic_rep / v_dc_rep / v_mem_rep  in  1 each  source has a valid flit
- ic_rep_ctrl / dc_rep_ctrl / mem_rep_ctrl  in  2 each  ctrl of the presented flit: 01 head, 10 body, 11 tail
- ack_OUT_rep  out  1  flit written into OUT_rep this cycle
- ack_ic_rep / ack_dc_rep / ack_mem_rep  out  1 each  the source's flit is consumed this cycle
- select  out  3  one-hot mux select for OUT_rep data: 100 ic, 010 dc, 001 mem, 000 none
- pkt_err  out  1  one-cycle registered pulse on watchdog abort

## Operation
- States, one-hot: IDLE=0001, IC_UP=0010, DC_UP=0100, MEM_UP=1000.
- A flit moves in a cycle only when OUT_rep_rdy=1. In that cycle ack_OUT_rep=1, exactly one ack_x_rep=1, and select is one-hot for that source. In every other cycle all acks=0 and select=000.
- IDLE:
  - Winner = highest-priority requester among the valid sources, chosen by the priority scheme (see Configuration).
  - The head flit is acked in the same cycle.
  - If the acked flit's ctrl=11 (single-flit packet), stay in IDLE. Otherwise go to the winner's UP state and load flit_cnt=1.
- X_UP:
  - Serve only source X; other valids are ignored.
  - If OUT_rep_rdy=1 and v_X=1: ack the flit and increment flit_cnt.
  - If that flit's ctrl=11, return to IDLE.
  - If OUT_rep_rdy=1 but v_X=0: no ack, state held. A source bubble never releases the port.
- Watchdog:
  - In X_UP, if flit_cnt reaches MAX_FLITS without a tail being acked, the state returns to IDLE on the next edge and pkt_err pulses on that edge.
  - The flit acked at count MAX_FLITS is still transferred.
- flit_cnt is 4 bits and is cleared on entry to IDLE.

## Timing
- Acks and select are combinational (Mealy) from state, valids, ctrl and OUT_rep_rdy. There is zero-cycle latency from request to ack in IDLE.
- State, flit_cnt, the priority pointer and pkt_err are registered.
- Reset values:
  - state=IDLE, flit_cnt=0, pointer=ic, pkt_err=0.
  - While rst=1, all acks=0 and select=000, regardless of inputs.
- Reset mid-packet: the next cycle is IDLE. The interrupted source re-arbitrates whatever flit it presents.
- A tail acked in X_UP and a new request in the following cycle: the new request is arbitrated in IDLE that following cycle. There is a 1-cycle minimum gap only in the sense that no flit moves on the tail cycle for another source.
- OUT_rep_rdy=0 in any state: no acks, no state or counter change.

## Configuration
- ARB_OUT_REP_RR_EN defined:
  - Round-robin. The pointer holds the last winner; the search order starts at the next source in ic→dc→mem→ic order.
  - The pointer updates only on an IDLE grant, including single-flit grants.
- Not defined:
  - Fixed priority ic > dc > mem. The pointer register is absent.
  - All other behaviour is identical.

## Test plan
- Single source: dc sends head/body/tail (01,10,11) with rdy=1 → ack_dc_rep high 3 consecutive cycles, select=010, return to IDLE after the tail.
- Contention under RR_EN: all three valid continuously with 2-flit packets → grant order ic, dc, mem, ic; no interleaving inside a packet.
- Contention without RR_EN: same stimulus → ic served repeatedly; dc and mem starve while ic is valid.
- Backpressure/bubble: rdy low 3 cycles mid-packet, then v_mem_rep low 2 cycles → no acks during either; packet completes intact; other sources are not granted.
- Single-flit packet: ic head with ctrl=11 → one ack, state stays IDLE; dc is granted the next cycle.
- Watchdog: MAX_FLITS=4, mem sends 01,10,10,10 with no tail → 4 acks, pkt_err=1 one cycle, then IDLE; a pending ic request is granted next.

Source files
------------

// File: rtl/arbiter_for_out_rep.sv
// Packet-atomic arbiter for the outgoing reply port (OUT_rep).
// Shares one reply register between the instruction cache, data cache and
// memory reply sources. A winning source owns the port until its tail flit
// is transferred. A flit-count watchdog frees the port if no tail arrives.
// Optional feature macro: ARB_OUT_REP_RR_EN selects round-robin arbitration.
// When the macro is undefined, the arbiter uses fixed priority ic > dc > mem.
module arbiter_for_out_rep #(
    parameter int MAX_FLITS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       OUT_rep_rdy,
    input  logic       v_ic_rep,
    input  logic       v_dc_rep,
    input  logic       v_mem_rep,
    input  logic [1:0] ic_rep_ctrl,
    input  logic [1:0] dc_rep_ctrl,
    input  logic [1:0] mem_rep_ctrl,
    output logic       ack_OUT_rep,
    output logic       ack_ic_rep,
    output logic       ack_dc_rep,
    output logic       ack_mem_rep,
    output logic [2:0] select,
    output logic       pkt_err
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        IC_UP  = 4'b0010,
        DC_UP  = 4'b0100,
        MEM_UP = 4'b1000
    } state_t;

    localparam logic [1:0] CTRL_TAIL = 2'b11;
    localparam logic [3:0] CNT_MAX   = 4'(MAX_FLITS);

    state_t     state;
    state_t     next_state;
    logic [3:0] flit_cnt;
    logic [3:0] next_cnt;
    logic       next_err;

    // Requests and grants use select ordering: bit2 ic, bit1 dc, bit0 mem.
    logic [2:0] req;
    logic [2:0] idle_grant;
    logic [2:0] grant;
    logic [1:0] grant_ctrl;

    assign req = {v_ic_rep, v_dc_rep, v_mem_rep};

`ifdef ARB_OUT_REP_RR_EN
    // Holds the one-hot identity of the last source granted from IDLE.
    logic [2:0] ptr;

    // Searches for a requester, starting at the source after the last winner.
    always_comb begin
        idle_grant = 3'b000;
        case (ptr)
            3'b100: begin
                if (req[1])      idle_grant = 3'b010;
                else if (req[0]) idle_grant = 3'b001;
                else if (req[2]) idle_grant = 3'b100;
            end
            3'b010: begin
                if (req[0])      idle_grant = 3'b001;
                else if (req[2]) idle_grant = 3'b100;
                else if (req[1]) idle_grant = 3'b010;
            end
            default: begin
                if (req[2])      idle_grant = 3'b100;
                else if (req[1]) idle_grant = 3'b010;
                else if (req[0]) idle_grant = 3'b001;
            end
        endcase
    end

    // Records the winner of every IDLE grant, including single-flit packets.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 3'b100;
        else if (state == IDLE && grant != 3'b000)
            ptr <= grant;
    end
`else
    // Fixed priority: ic beats dc, and dc beats mem.
    always_comb begin
        idle_grant = 3'b000;
        if (req[2])      idle_grant = 3'b100;
        else if (req[1]) idle_grant = 3'b010;
        else if (req[0]) idle_grant = 3'b001;
    end
`endif

    // Produces the Mealy grant, the next state, the flit count and the
    // watchdog abort. No flit moves during reset or while OUT_rep is not ready.
    always_comb begin
        grant      = 3'b000;
        next_state = state;
        next_cnt   = flit_cnt;
        next_err   = 1'b0;
        case (state)
            IDLE:    if (!rst && OUT_rep_rdy) grant = idle_grant;
            IC_UP:   if (!rst && OUT_rep_rdy) grant = {v_ic_rep, 2'b00};
            DC_UP:   if (!rst && OUT_rep_rdy) grant = {1'b0, v_dc_rep, 1'b0};
            MEM_UP:  if (!rst && OUT_rep_rdy) grant = {2'b00, v_mem_rep};
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase

        if (grant[2])      grant_ctrl = ic_rep_ctrl;
        else if (grant[1]) grant_ctrl = dc_rep_ctrl;
        else               grant_ctrl = mem_rep_ctrl;

        if (grant != 3'b000) begin
            if (state == IDLE) begin
                if (grant_ctrl != CTRL_TAIL) begin
                    if (grant[2])      next_state = IC_UP;
                    else if (grant[1]) next_state = DC_UP;
                    else               next_state = MEM_UP;
                    next_cnt = 4'd1;
                end
            end else begin
                next_cnt = flit_cnt + 4'd1;
                if (grant_ctrl == CTRL_TAIL) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else if (flit_cnt + 4'd1 == CNT_MAX) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                    next_err   = 1'b1;
                end
            end
        end
    end

    assign ack_OUT_rep = |grant;
    assign ack_ic_rep  = grant[2];
    assign ack_dc_rep  = grant[1];
    assign ack_mem_rep = grant[0];
    assign select      = grant;

    // Registers the state, the flit count and the one-cycle watchdog pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flit_cnt <= 4'd0;
            pkt_err  <= 1'b0;
        end else begin
            state    <= next_state;
            flit_cnt <= next_cnt;
            pkt_err  <= next_err;
        end
    end

endmodule

// File: tb/tb_arbiter_for_out_rep.sv
// Self-checking bench for arbiter_for_out_rep using a behavioural port-ownership model.
module tb_arbiter_for_out_rep;

    localparam int MAX = 4;
`ifdef ARB_OUT_REP_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy = 1'b0;
    logic       v_ic = 1'b0, v_dc = 1'b0, v_mem = 1'b0;
    logic [1:0] c_ic = 2'b00, c_dc = 2'b00, c_mem = 2'b00;
    logic       ack_out, ack_ic, ack_dc, ack_mem;
    logic [2:0] select;
    logic       pkt_err;

    int vectors = 0;
    int miscompares = 0;

    // Model: port owner (-1 none, 0 ic, 1 dc, 2 mem), flits moved, last winner.
    int   owner = -1;
    int   cnt = 0;
    int   ptr = 0;
    logic err_exp = 1'b0;

    // Per-source packet generator state for random traffic.
    int plen[3];
    int ppos[3];

    always #5 clk = ~clk;

    arbiter_for_out_rep #(.MAX_FLITS(MAX)) dut (
        .clk(clk),
        .rst(rst),
        .OUT_rep_rdy(rdy),
        .v_ic_rep(v_ic),
        .v_dc_rep(v_dc),
        .v_mem_rep(v_mem),
        .ic_rep_ctrl(c_ic),
        .dc_rep_ctrl(c_dc),
        .mem_rep_ctrl(c_mem),
        .ack_OUT_rep(ack_out),
        .ack_ic_rep(ack_ic),
        .ack_dc_rep(ack_dc),
        .ack_mem_rep(ack_mem),
        .select(select),
        .pkt_err(pkt_err)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic int pickWinner(input logic [2:0] v);
        int start;
        start = RR ? ptr + 1 : 0;
        for (int k = 0; k < 3; k++) begin
            if (v[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic applyStimulus(input logic r, input logic rd, input logic [2:0] v,
                                 input logic [1:0] c0, input logic [1:0] c1,
                                 input logic [1:0] c2, output int g);
        logic [1:0] c[3];
        logic [7:0] exp;
        c[0] = c0; c[1] = c1; c[2] = c2;
        @(negedge clk);
        rst = r; rdy = rd;
        v_ic = v[0]; v_dc = v[1]; v_mem = v[2];
        c_ic = c0; c_dc = c1; c_mem = c2;
        #1;
        g = -1;
        if (!r && rd) begin
            if (owner < 0) g = pickWinner(v);
            else if (v[owner]) g = owner;
        end
        exp = 8'h00;
        if (g >= 0) begin
            exp[6] = 1'b1;
            exp[5 - g] = 1'b1;
            exp[2 - g] = 1'b1;
        end
        checkOutput("acks_select", {1'b0, ack_out, ack_ic, ack_dc, ack_mem, select}, exp);
        checkOutput("pkt_err", {7'b0, pkt_err}, {7'b0, err_exp});
        @(posedge clk);
        if (r) begin
            owner = -1; cnt = 0; ptr = 0; err_exp = 1'b0;
        end else begin
            err_exp = 1'b0;
            if (g >= 0) begin
                if (owner < 0) begin
                    ptr = g;
                    if (c[g] != 2'b11) begin
                        owner = g;
                        cnt = 1;
                    end
                end else begin
                    cnt++;
                    if (c[g] == 2'b11) begin
                        owner = -1; cnt = 0;
                    end else if (cnt == MAX) begin
                        owner = -1; cnt = 0; err_exp = 1'b1;
                    end
                end
            end
        end
    endtask

    function automatic logic [1:0] genCtrl(input int s);
        if (ppos[s] == 0) return (plen[s] == 1) ? 2'b11 : 2'b01;
        if (ppos[s] == plen[s] - 1) return 2'b11;
        return 2'b10;
    endfunction

    initial begin
        int g;
        logic [2:0] v;
        logic r, rd;
        repeat (2) @(posedge clk);

        applyStimulus(1'b1, 1'b1, 3'b111, 2'b01, 2'b01, 2'b01, g);

        // dc sends head, body, tail
        applyStimulus(1'b0, 1'b1, 3'b010, 2'b00, 2'b01, 2'b00, g);
        applyStimulus(1'b0, 1'b1, 3'b010, 2'b00, 2'b10, 2'b00, g);
        applyStimulus(1'b0, 1'b1, 3'b010, 2'b00, 2'b11, 2'b00, g);
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, g);

        // single-flit ic packet followed by a dc grant
        applyStimulus(1'b0, 1'b1, 3'b011, 2'b11, 2'b01, 2'b00, g);
        applyStimulus(1'b0, 1'b1, 3'b010, 2'b00, 2'b11, 2'b00, g);

        // mem watchdog with ic waiting
        applyStimulus(1'b0, 1'b1, 3'b100, 2'b00, 2'b00, 2'b01, g);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 3'b101, 2'b01, 2'b00, 2'b10, g);
        applyStimulus(1'b0, 1'b1, 3'b001, 2'b11, 2'b00, 2'b00, g);
        applyStimulus(1'b0, 1'b1, 3'b000, 2'b00, 2'b00, 2'b00, g);

        // mem backpressure then source bubble with other sources waiting
        applyStimulus(1'b0, 1'b1, 3'b100, 2'b00, 2'b00, 2'b01, g);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 3'b111, 2'b01, 2'b01, 2'b10, g);
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 1'b1, 3'b011, 2'b01, 2'b01, 2'b10, g);
        applyStimulus(1'b0, 1'b1, 3'b111, 2'b01, 2'b01, 2'b11, g);

        // contention with 2-flit packets on all sources
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, 3'b111, (i % 2 == 0) ? 2'b01 : 2'b11,
                          (i % 2 == 0) ? 2'b01 : 2'b11, (i % 2 == 0) ? 2'b01 : 2'b11, g);

        // random traffic
        for (int s = 0; s < 3; s++) begin
            plen[s] = $urandom_range(1, 6);
            ppos[s] = 0;
        end
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) < 8);
            for (int s = 0; s < 3; s++) v[s] = ($urandom_range(0, 3) != 0);
            applyStimulus(r, rd, v, genCtrl(0), genCtrl(1), genCtrl(2), g);
            if (g >= 0) begin
                ppos[g]++;
                if (ppos[g] >= plen[g]) begin
                    ppos[g] = 0;
                    plen[g] = $urandom_range(1, 6);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
